demux_2way_buf: RTL and testbench
=================================

DEMUX_2WAY_BUF -- requirements
Module: demux_2way_buf

Interface
REQ-001 Parameter WIDTH, default 32, data width of input and both outputs.
REQ-002 Parameter DEPTH, default 2, entries per output buffer; SHALL be 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  source offers a word.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 in_data  input  WIDTH  offered word.
REQ-008 select  input  1  destination of the offered word: 0 routes to out0, 1 routes to out1.
REQ-009 out0_valid / out1_valid  output  1  buffer head valid.
REQ-010 out0_ready / out1_ready  input  1  sink accepts the head.
REQ-011 out0_data / out1_data  output  WIDTH  buffer head word.

Function
REQ-012 Transfer on a port SHALL occur when valid and ready are both high at a rising edge.
REQ-013 in_ready SHALL be combinational: high when the buffer named by select is not full, or when it is full and its sink pops in the same cycle.
REQ-014 Each output buffer SHALL be a FIFO of DEPTH entries with a count from 0 to DEPTH.
REQ-015 An accepted word SHALL appear as the selected output's head no earlier than one cycle after acceptance; latency into an empty buffer SHALL be exactly 1 cycle.
REQ-016 outN_data SHALL be driven from a register; it SHALL have no combinational path from in_data.
REQ-017 Words SHALL leave each output in acceptance order; the two outputs SHALL be independent, with no ordering between them.
REQ-018 Simultaneous push and pop on a full buffer SHALL leave its count at DEPTH with no loss.
REQ-019 Simultaneous push and pop on an empty buffer SHALL leave its count at 1; the word SHALL NOT bypass the buffer.
REQ-020 A pop while count is 0 SHALL NOT occur because valid is low; the count SHALL never underflow or exceed DEPTH.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 A stall on one output SHALL NOT block words selected for the other output.
REQ-023 outN_valid and outN_data SHALL hold stable while outN_ready is low.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear both counts and pointers and drive out0_valid and out1_valid to 0.
REQ-025 Output data registers SHALL reset to 0.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered words; no partial transfer SHALL complete.
REQ-027 in_ready SHALL be 0 while rst_n is low.

Configuration
REQ-028 Macro DEMUX_COUNT_EN defined: the block SHALL add outputs cnt0 and cnt1 (32 bits each), counting completed transfers per output, wrapping at 2^32 and cleared by reset.
REQ-029 DEMUX_COUNT_EN undefined: cnt0, cnt1 and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package mips_pkg SHALL hold the DATA_WIDTH (32) constant and the port-index constants OUT0 (0) and OUT1 (1).
REQ-031 Each output buffer SHALL be one instance of sub-module demux_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full); exactly two instances.

Verification
REQ-032 Reset then in_data=2, select=0, one-cycle valid -> out0_valid=1 with data 2 on the next cycle; out1_valid stays 0.
REQ-033 Hold out1_ready=0 and push 3, 4, 5 with select=1 (DEPTH=2) -> in_ready=0 at the third word; after out1_ready=1, the output order is 3 then 4 then 5.
REQ-034 out0 full and stalled; push 7 with select=1 -> accepted at once; out1 delivers 7 one cycle later.
REQ-035 out0 full while out0_ready=1 and in_valid=1 with select=0 -> pop and push occur in the same cycle; count stays 2; no word is lost or duplicated.
REQ-036 Assert rst_n low while both buffers hold data -> both valids drop to 0 asynchronously; the first word after release appears with 1-cycle latency.
REQ-037 With DEMUX_COUNT_EN defined, 10 transfers to out0 and 3 to out1 -> cnt0=10 and cnt1=3; after reset both read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared width and output-port index constants for the 2-way demux.
package mips_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int OUT0 = 0;
  localparam int OUT1 = 1;
endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: DEPTH-entry register FIFO; head is read straight from storage,
// so dout never has a path from din and pushes into an empty FIFO appear one cycle later.
module demux_fifo
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = cnt_q == CW'(0);
  assign full    = cnt_q == CW'(DEPTH);
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is legal only when the head leaves on the same edge
  assign do_push = push & (~full | do_pop);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/demux_2way_buf.sv
// demux_2way_buf: routes a valid/ready stream to one of two independently buffered outputs.
// Optional DEMUX_COUNT_EN adds per-output completed-transfer counters cnt0/cnt1.
module demux_2way_buf
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [31:0]      cnt0,
  output logic [31:0]      cnt1
`endif
);
  logic [1:0] push, pop, empty, full, out_ready;

  assign out_ready[OUT0] = out0_ready;
  assign out_ready[OUT1] = out1_ready;
  assign out0_valid      = ~empty[OUT0];
  assign out1_valid      = ~empty[OUT1];
  assign pop             = out_ready & ~empty;
  // a full buffer still accepts when its own sink drains it this cycle
  assign in_ready        = rst_n & (~full[select] | pop[select]);
  assign push[OUT0]      = in_valid & in_ready & ~select;
  assign push[OUT1]      = in_valid & in_ready & select;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push[OUT0]),
    .pop   (pop[OUT0]),
    .din   (in_data),
    .dout  (out0_data),
    .empty (empty[OUT0]),
    .full  (full[OUT0])
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push[OUT1]),
    .pop   (pop[OUT1]),
    .din   (in_data),
    .dout  (out1_data),
    .empty (empty[OUT1]),
    .full  (full[OUT1])
  );

`ifdef DEMUX_COUNT_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (pop[OUT0]) cnt0_q <= cnt0_q + 32'd1;
      if (pop[OUT1]) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_demux_2way_buf.sv
// tb_demux_2way_buf: directed and random stimulus against a queue-based reference model.
module tb_demux_2way_buf;
  localparam int W = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, select = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out0_ready = 1'b0, out1_ready = 1'b0;
  logic         in_ready, out0_valid, out1_valid;
  logic [W-1:0] out0_data, out1_data;
`ifdef DEMUX_COUNT_EN
  logic [31:0]  cnt0, cnt1;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] q0[$], q1[$];
  int n0 = 0, n1 = 0;

  demux_2way_buf #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .select     (select),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called just after a rising edge: drive, check against the model, then advance one cycle
  task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1);
    logic exp_rdy, p0, p1;
    in_valid = v; select = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    chk("out0_valid", out0_valid, W'(q0.size() > 0));
    chk("out1_valid", out1_valid, W'(q1.size() > 0));
    if (q0.size() > 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
    p0 = r0 && q0.size() > 0;
    p1 = r1 && q1.size() > 0;
    exp_rdy = s ? (q1.size() < DEPTH || p1) : (q0.size() < DEPTH || p0);
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    if (p0) begin void'(q0.pop_front()); n0++; end
    if (p1) begin void'(q1.pop_front()); n1++; end
    if (v && exp_rdy) begin
      if (s) q1.push_back(d); else q0.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  // asynchronous reset asserted between edges with a word still being offered
  task automatic do_reset();
    @(posedge clk); #2;
    in_valid = 1'b1; select = 1'b0; in_data = 32'hdead;
    rst_n = 1'b0;
    #1;
    chk("rst_out0_valid", W'(out0_valid), W'(0));
    chk("rst_out1_valid", W'(out1_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out0_data", out0_data, '0);
    chk("rst_out1_data", out1_data, '0);
`ifdef DEMUX_COUNT_EN
    chk("rst_cnt0", cnt0, '0);
    chk("rst_cnt1", cnt1, '0);
`endif
    q0.delete(); q1.delete(); n0 = 0; n1 = 0;
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("init_out0_valid", W'(out0_valid), W'(0));
    chk("init_out1_valid", W'(out1_valid), W'(0));
    chk("init_in_ready", W'(in_ready), W'(0));
    do_reset();

    // single word to out0, visible next cycle
    step(1, 0, 32'd2, 0, 0);
    chk("single_v0", W'(out0_valid), W'(1));
    chk("single_d0", out0_data, 32'd2);
    chk("single_v1", W'(out1_valid), W'(0));

    // out1 stalled: third word is refused, then order 3,4,5 after release
    step(1, 1, 32'd3, 0, 0);
    step(1, 1, 32'd4, 0, 0);
    step(1, 1, 32'd5, 0, 0);
    step(1, 1, 32'd5, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 1);

    // out0 full and stalled does not block out1
    step(1, 0, 32'd6, 0, 0);
    step(1, 1, 32'd7, 0, 0);
    chk("bypass_v1", W'(out1_valid), W'(1));
    chk("bypass_d1", out1_data, 32'd7);
    step(0, 0, '0, 0, 1);

    // out0 full with simultaneous pop and push
    step(1, 0, 32'd9, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);

    // reset with both buffers occupied, then 1-cycle latency afterwards
    step(1, 0, 32'h11, 0, 0);
    step(1, 1, 32'h22, 0, 0);
    do_reset();
    step(1, 1, 32'h55, 0, 0);
    chk("post_rst_v1", W'(out1_valid), W'(1));
    chk("post_rst_d1", out1_data, 32'h55);
    step(0, 0, '0, 0, 1);

    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           ($urandom % 4) != 0, ($urandom % 3) != 0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1, 1);
`ifdef DEMUX_COUNT_EN
    chk("rand_cnt0", cnt0, W'(n0));
    chk("rand_cnt1", cnt1, W'(n1));
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, W'(100 + i), 1, 1);
    for (int i = 0; i < 3; i++) step(1, 1, W'(200 + i), 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1);
    chk("cnt0_ten", cnt0, 32'd10);
    chk("cnt1_three", cnt1, 32'd3);
    do_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
